// File: rtl/mem_stage.sv
// Memory-access stage: doubleword data memory, branch resolve, MEM/WB register.
// Misaligned accesses are suppressed and flagged to write-back as a fault.
module mem_stage #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] EXMEM_out,
    input  logic        EXMEM_ZERO,
    input  logic [63:0] EXMEM_Result,
    input  logic [63:0] EXMEM_ReadData2,
    input  logic [4:0]  EXMEM_inst2,
    input  logic        EXMEM_Branch,
    input  logic        EXMEM_MemRead,
    input  logic        EXMEM_MemWrite,
    input  logic        EXMEM_MemtoReg,
    input  logic        EXMEM_RegWrite,
    output logic        PCSrc,
    output logic [63:0] BranchTarget,
    output logic [63:0] MEMWB_ReadData,
    output logic [63:0] MEMWB_Result,
    output logic [4:0]  MEMWB_rd,
    output logic        MEMWB_RegWrite,
    output logic        MEMWB_MemtoReg,
    output logic        MEMWB_Fault
);

    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] idx;
    logic              misaligned;
    logic              do_load;
    logic              do_store;
    logic [63:0]       rdata;

    assign PCSrc        = EXMEM_Branch & EXMEM_ZERO;
    assign BranchTarget = EXMEM_out;

    assign idx        = EXMEM_Result[ADDR_W-1:0];
    assign misaligned = (EXMEM_Result[2:0] != 3'd0)
                      & (EXMEM_MemRead | EXMEM_MemWrite);
    assign do_load    = EXMEM_MemRead & ~misaligned;
    assign do_store   = EXMEM_MemWrite & ~misaligned;

    // Little-endian gather; aligned accesses never cross the array end.
    always_comb begin
        rdata = '0;
        for (int i = 0; i < 8; i++) begin
            rdata[8*i +: 8] = mem[idx + ADDR_W'(i)];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (do_store) begin
            for (int i = 0; i < 8; i++) begin
                mem[idx + ADDR_W'(i)] <= EXMEM_ReadData2[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            MEMWB_ReadData <= '0;
            MEMWB_Result   <= '0;
            MEMWB_rd       <= '0;
            MEMWB_RegWrite <= 1'b0;
            MEMWB_MemtoReg <= 1'b0;
            MEMWB_Fault    <= 1'b0;
        end else begin
            MEMWB_ReadData <= do_load ? rdata : 64'd0;
            MEMWB_Result   <= EXMEM_Result;
            MEMWB_rd       <= EXMEM_inst2;
            MEMWB_RegWrite <= EXMEM_RegWrite & ~misaligned;
            MEMWB_MemtoReg <= EXMEM_MemtoReg;
            MEMWB_Fault    <= misaligned;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: reset, store/load, wrap, misalignment,
// branch resolve and read-before-write.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] EXMEM_out;
    logic        EXMEM_ZERO;
    logic [63:0] EXMEM_Result;
    logic [63:0] EXMEM_ReadData2;
    logic [4:0]  EXMEM_inst2;
    logic        EXMEM_Branch;
    logic        EXMEM_MemRead;
    logic        EXMEM_MemWrite;
    logic        EXMEM_MemtoReg;
    logic        EXMEM_RegWrite;
    logic        PCSrc;
    logic [63:0] BranchTarget;
    logic [63:0] MEMWB_ReadData;
    logic [63:0] MEMWB_Result;
    logic [4:0]  MEMWB_rd;
    logic        MEMWB_RegWrite;
    logic        MEMWB_MemtoReg;
    logic        MEMWB_Fault;

    int n_checks = 0;
    int n_fail   = 0;

    mem_stage #(.DEPTH(256)) dut (
        .clk(clk),
        .reset(reset),
        .EXMEM_out(EXMEM_out),
        .EXMEM_ZERO(EXMEM_ZERO),
        .EXMEM_Result(EXMEM_Result),
        .EXMEM_ReadData2(EXMEM_ReadData2),
        .EXMEM_inst2(EXMEM_inst2),
        .EXMEM_Branch(EXMEM_Branch),
        .EXMEM_MemRead(EXMEM_MemRead),
        .EXMEM_MemWrite(EXMEM_MemWrite),
        .EXMEM_MemtoReg(EXMEM_MemtoReg),
        .EXMEM_RegWrite(EXMEM_RegWrite),
        .PCSrc(PCSrc),
        .BranchTarget(BranchTarget),
        .MEMWB_ReadData(MEMWB_ReadData),
        .MEMWB_Result(MEMWB_Result),
        .MEMWB_rd(MEMWB_rd),
        .MEMWB_RegWrite(MEMWB_RegWrite),
        .MEMWB_MemtoReg(MEMWB_MemtoReg),
        .MEMWB_Fault(MEMWB_Fault)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic rd_en, input logic wr_en,
                          input logic m2r, input logic rw,
                          input logic [63:0] addr, input logic [63:0] data,
                          input logic [4:0] rdst);
        EXMEM_MemRead   = rd_en;
        EXMEM_MemWrite  = wr_en;
        EXMEM_MemtoReg  = m2r;
        EXMEM_RegWrite  = rw;
        EXMEM_Result    = addr;
        EXMEM_ReadData2 = data;
        EXMEM_inst2     = rdst;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        EXMEM_Branch = 1'b0;
        EXMEM_ZERO = 1'b0;
        EXMEM_out = '0;
        set_op(1'b0, 1'b1, 1'b1, 1'b1, 64'h10, 64'hFFFF_FFFF_FFFF_FFFF, 5'd7);
        for (int c = 0; c < 2; c++) begin
            tick();
            n_checks++;
            if ({MEMWB_ReadData, MEMWB_Result, MEMWB_rd, MEMWB_RegWrite,
                 MEMWB_MemtoReg, MEMWB_Fault} !== '0) begin
                n_fail++;
                $display("FAIL reset_outputs: got rd=%h res=%h rdst=%0d rw=%b m2r=%b f=%b required all zero",
                         MEMWB_ReadData, MEMWB_Result, MEMWB_rd,
                         MEMWB_RegWrite, MEMWB_MemtoReg, MEMWB_Fault);
            end
        end
        reset = 1'b0;
        set_op(1'b1, 1'b0, 1'b1, 1'b1, 64'h10, 64'h0, 5'd3);
        tick();
        n_checks++;
        if (MEMWB_ReadData !== 64'h0) begin
            n_fail++;
            $display("FAIL reset_store_discarded: got %h required 0", MEMWB_ReadData);
        end
    endtask

    task automatic test_back_to_back();
        set_op(1'b0, 1'b1, 1'b0, 1'b0, 64'h08, 64'h1122334455667788, 5'd0);
        tick();
        n_checks++;
        if (MEMWB_ReadData !== 64'h0) begin
            n_fail++;
            $display("FAIL no_read_zero: got %h required 0", MEMWB_ReadData);
        end
        set_op(1'b1, 1'b0, 1'b1, 1'b1, 64'h08, 64'h0, 5'd5);
        tick();
        n_checks++;
        if (MEMWB_ReadData !== 64'h1122334455667788) begin
            n_fail++;
            $display("FAIL b2b_load: got %h required 1122334455667788", MEMWB_ReadData);
        end
        n_checks++;
        if ({MEMWB_Result, MEMWB_rd, MEMWB_RegWrite, MEMWB_MemtoReg, MEMWB_Fault}
            !== {64'h08, 5'd5, 1'b1, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL b2b_ctrl: got res=%h rd=%0d rw=%b m2r=%b f=%b required 8,5,1,1,0",
                     MEMWB_Result, MEMWB_rd, MEMWB_RegWrite, MEMWB_MemtoReg, MEMWB_Fault);
        end
        n_checks++;
        if (dut.mem[8] !== 8'h88 || dut.mem[15] !== 8'h11) begin
            n_fail++;
            $display("FAIL byte_order: got mem[8]=%h mem[15]=%h required 88 11",
                     dut.mem[8], dut.mem[15]);
        end
    endtask

    task automatic test_wrap();
        set_op(1'b0, 1'b1, 1'b0, 1'b0, 64'h1F8, 64'hA5A5A5A5A5A5A5A5, 5'd0);
        tick();
        set_op(1'b1, 1'b0, 1'b1, 1'b1, 64'hF8, 64'h0, 5'd9);
        tick();
        n_checks++;
        if (MEMWB_ReadData !== 64'hA5A5A5A5A5A5A5A5) begin
            n_fail++;
            $display("FAIL wrap_load: got %h required a5a5a5a5a5a5a5a5", MEMWB_ReadData);
        end
    endtask

    task automatic test_misaligned();
        set_op(1'b0, 1'b1, 1'b0, 1'b1, 64'h0C, 64'hDEADBEEFCAFEF00D, 5'd2);
        tick();
        n_checks++;
        if ({MEMWB_Fault, MEMWB_RegWrite} !== 2'b10) begin
            n_fail++;
            $display("FAIL mis_store_flags: got fault=%b rw=%b required 1 0",
                     MEMWB_Fault, MEMWB_RegWrite);
        end
        set_op(1'b1, 1'b0, 1'b1, 1'b1, 64'h0C, 64'h0, 5'd4);
        tick();
        n_checks++;
        if ({MEMWB_ReadData, MEMWB_Fault, MEMWB_RegWrite} !== {64'h0, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL mis_load: got data=%h fault=%b rw=%b required 0 1 0",
                     MEMWB_ReadData, MEMWB_Fault, MEMWB_RegWrite);
        end
        set_op(1'b1, 1'b0, 1'b1, 1'b1, 64'h08, 64'h0, 5'd4);
        tick();
        n_checks++;
        if ({MEMWB_ReadData, MEMWB_Fault, MEMWB_RegWrite}
            !== {64'h1122334455667788, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL mis_after_lo: got data=%h fault=%b rw=%b required 1122334455667788 0 1",
                     MEMWB_ReadData, MEMWB_Fault, MEMWB_RegWrite);
        end
        set_op(1'b1, 1'b0, 1'b1, 1'b1, 64'h10, 64'h0, 5'd4);
        tick();
        n_checks++;
        if (MEMWB_ReadData !== 64'h0) begin
            n_fail++;
            $display("FAIL mis_after_hi: got %h required 0", MEMWB_ReadData);
        end
    endtask

    task automatic test_branch();
        set_op(1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 5'd0);
        EXMEM_Branch = 1'b1;
        EXMEM_ZERO   = 1'b1;
        EXMEM_out    = 64'h40;
        #1;
        n_checks++;
        if ({PCSrc, BranchTarget} !== {1'b1, 64'h40}) begin
            n_fail++;
            $display("FAIL branch_taken: got pcsrc=%b tgt=%h required 1 40", PCSrc, BranchTarget);
        end
        EXMEM_ZERO = 1'b0;
        #1;
        n_checks++;
        if (PCSrc !== 1'b0) begin
            n_fail++;
            $display("FAIL branch_not_taken: got %b required 0", PCSrc);
        end
        EXMEM_ZERO = 1'b1;
        EXMEM_out  = 64'h1234;
        reset = 1'b1;
        #1;
        n_checks++;
        if ({PCSrc, BranchTarget} !== {1'b1, 64'h1234}) begin
            n_fail++;
            $display("FAIL branch_in_reset: got pcsrc=%b tgt=%h required 1 1234", PCSrc, BranchTarget);
        end
        reset = 1'b0;
        EXMEM_Branch = 1'b0;
        EXMEM_ZERO   = 1'b0;
        tick();
    endtask

    task automatic test_rbw();
        set_op(1'b0, 1'b1, 1'b0, 1'b0, 64'h20, 64'd5, 5'd0);
        tick();
        set_op(1'b1, 1'b1, 1'b1, 1'b1, 64'h20, 64'd9, 5'd6);
        tick();
        n_checks++;
        if (MEMWB_ReadData !== 64'd5) begin
            n_fail++;
            $display("FAIL rbw_old: got %h required 5", MEMWB_ReadData);
        end
        set_op(1'b1, 1'b0, 1'b1, 1'b1, 64'h20, 64'd0, 5'd6);
        tick();
        n_checks++;
        if (MEMWB_ReadData !== 64'd9) begin
            n_fail++;
            $display("FAIL rbw_new: got %h required 9", MEMWB_ReadData);
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_wrap();
        test_misaligned();
        test_branch();
        test_rbw();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the 64-bit pipelined core. It consumes the EX/MEM pipeline register outputs and owns the byte-addressed data memory. It resolves the branch decision for the fetch stage and registers the MEM/WB pipeline state consumed by write-back. Doubleword (64-bit) little-endian loads and stores only.

## Interface
Parameters:
- DEPTH, 256: data memory size in bytes; power of two, ≥ 8.
- ADDR_W, $clog2(DEPTH): derived; byte-index width.

Ports:
- clk  input  1  pipeline clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high; sampled on rising edge of clk.
- EXMEM_out  input  64  branch target address.
- EXMEM_ZERO  input  1  ALU zero flag.
- EXMEM_Result  input  64  ALU result: memory byte address, or the write-back value.
- EXMEM_ReadData2  input  64  store data.
- EXMEM_inst2  input  5  destination register (rd).
- EXMEM_Branch, EXMEM_MemRead, EXMEM_MemWrite, EXMEM_MemtoReg, EXMEM_RegWrite  input  1 each  control bits.
- PCSrc  output  1  combinational; EXMEM_Branch & EXMEM_ZERO.
- BranchTarget  output  64  combinational; equals EXMEM_out.
- MEMWB_ReadData  output  64  registered load data.
- MEMWB_Result  output  64  registered EXMEM_Result.
- MEMWB_rd  output  5  registered EXMEM_inst2.
- MEMWB_RegWrite, MEMWB_MemtoReg  output  1 each  registered controls.
- MEMWB_Fault  output  1  registered; misaligned access occurred in the captured instruction.

## Operation
- Memory: DEPTH × 8-bit register array. Index = EXMEM_Result[ADDR_W-1:0]. Upper address bits are ignored, so addresses wrap modulo DEPTH.
- Alignment: an access is misaligned when EXMEM_Result[2:0] != 0 and (MemRead | MemWrite).
- Load (MemRead, aligned): combinational read of bytes idx..idx+7, little-endian (byte idx = bits [7:0]). The result is captured into MEMWB_ReadData on the next edge.
- Store (MemWrite, aligned): bytes idx..idx+7 are written with EXMEM_ReadData2 little-endian on the rising edge.
- Misaligned access:
  - The store is suppressed; memory is unchanged.
  - Load data is captured as 0.
  - MEMWB_RegWrite is forced to 0.
  - MEMWB_Fault is captured as 1.
- MemRead and MemWrite both set (aligned): read-before-write. MEMWB_ReadData captures the old contents, and the memory takes the new data.
- No MemRead: MEMWB_ReadData captures 0.
- All other MEMWB_* fields capture their inputs unchanged every non-reset cycle. There is no stall or flush input; the stage advances every cycle.
- PCSrc and BranchTarget are purely combinational from current inputs and are unaffected by reset.

## Timing
- Reset (synchronous):
  - All MEMWB_* outputs become 0.
  - Every memory byte becomes 0.
  - A store presented in the reset cycle is discarded.
  - Reset wins over any simultaneous access.
- Latency: inputs present in cycle N appear on MEMWB_* after the rising edge that ends cycle N, which is 1 cycle.
- Store visibility: a store in cycle N is readable by a load in cycle N+1 at the same address, with no bubble.
- Wrap: address DEPTH-8+DEPTH*k maps to the top doubleword. Aligned accesses never straddle the array end, because DEPTH is a multiple of 8.
- The fault is held for exactly one cycle per faulting instruction. There is no sticky state.

## Test plan
- Reset: assert reset 2 cycles with MemWrite=1, addr 0x10, data 0xFFFF… Then deassert, and load 0x10. Required: all MEMWB_* = 0 during reset; the load returns 0.
- Store/load back-to-back: store 0x1122334455667788 to 0x08 in cycle N, then load 0x08 in cycle N+1. Required: MEMWB_ReadData = 0x1122334455667788 after cycle N+1, MEMWB_MemtoReg/RegWrite pass through, and byte 0x08 = 0x88.
- Wrap: with DEPTH=256, store 0xA5A5… to 0x1F8, then load 0xF8. Required: the load returns 0xA5A5…A5.
- Misaligned: store to 0x0C, then load 0x0C with RegWrite=1. Required: memory unchanged, MEMWB_ReadData=0, MEMWB_RegWrite=0, MEMWB_Fault=1 for one cycle, then Fault=0 on the next aligned op.
- Branch: Branch=1, ZERO=1, out=0x40. Required: PCSrc=1 and BranchTarget=0x40 in the same cycle. With ZERO=0, PCSrc=0.
- Read-before-write: mem[0x20]=5, then MemRead=MemWrite=1 at 0x20 with data 9. Required: MEMWB_ReadData=5; a following load returns 9.
